// File: rtl/dmem_arbiter_if.sv
// Requester-side bus for the data-memory arbiter: request/write fields
// driven by the requester, grant and registered response driven back.
interface dmem_arbiter_if #(
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [31:0]   addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of the single-port data memory, with a
// bounded lock for the CSR/trap unit, registered read responses and range check.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  m0,
  dmem_arbiter_if.slave  m1,
  input  logic           m1_lock,
  output logic [31:0]    mem_addr,
  output logic           mem_we,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata
);

  localparam int   CW      = $clog2(LOCK_MAX + 1);
  localparam logic LOCK_EN = (LOCK_MAX > 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e          state_r;
  state_e          state_s;
  logic            last_r;
  logic            last_s;
  logic [CW-1:0]   lock_cnt_r;
  logic [CW-1:0]   lock_cnt_s;
  logic [CW-1:0]   lock_cnt_inc_s;
  logic            gnt0_s;
  logic            gnt1_s;
  logic            ok0_s;
  logic            ok1_s;

  logic            rvalid0_r;
  logic            rvalid1_r;
  logic            err0_r;
  logic            err1_r;
  logic [DW-1:0]   rdata0_r;
  logic [DW-1:0]   rdata1_r;

  // Address lies inside the 2**AW-word memory
  function automatic logic addr_in_range(input logic [31:0] a);
    addr_in_range = ((a >> AW) == 32'd0);
  endfunction

  assign ok0_s          = addr_in_range(m0.addr);
  assign ok1_s          = addr_in_range(m1.addr);
  assign lock_cnt_inc_s = lock_cnt_r + CW'(1);

  // Grant decision, round-robin pointer and lock sequencing
  always_comb begin
    state_s    = state_r;
    last_s     = last_r;
    lock_cnt_s = lock_cnt_r;
    gnt0_s     = 1'b0;
    gnt1_s     = 1'b0;
    if (rst) begin
      state_s    = IDLE;
      last_s     = 1'b1;
      lock_cnt_s = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (m0.req && m1.req) begin
            gnt0_s = last_r;
            gnt1_s = !last_r;
          end else begin
            gnt0_s = m0.req;
            gnt1_s = m1.req;
          end
          if (gnt0_s) begin
            last_s = 1'b0;
          end else if (gnt1_s) begin
            last_s = 1'b1;
          end else begin
            last_s = last_r;
          end
          if (gnt1_s && m1_lock && LOCK_EN) begin
            state_s    = LOCKED;
            lock_cnt_s = CW'(1);
          end else begin
            state_s    = IDLE;
            lock_cnt_s = '0;
          end
        end
        LOCKED: begin
          gnt1_s     = m1.req;
          lock_cnt_s = lock_cnt_inc_s;
          if (gnt1_s) begin
            last_s = 1'b1;
          end else begin
            last_s = last_r;
          end
          // Forced release hands priority to the pipeline on the next conflict
          if (!m1_lock) begin
            state_s    = IDLE;
            lock_cnt_s = '0;
          end else if (lock_cnt_inc_s >= CW'(LOCK_MAX)) begin
            state_s    = IDLE;
            last_s     = 1'b1;
            lock_cnt_s = '0;
          end else begin
            state_s = LOCKED;
          end
        end
        default: begin
          state_s    = IDLE;
          last_s     = 1'b1;
          lock_cnt_s = '0;
        end
      endcase
    end
  end

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      last_r     <= 1'b1;
      lock_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      last_r     <= last_s;
      lock_cnt_r <= lock_cnt_s;
    end
  end

  // Memory-side mux from the granted requester
  always_comb begin
    mem_addr  = 32'd0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (gnt0_s) begin
      mem_addr  = m0.addr;
      mem_we    = m0.we && ok0_s;
      mem_wdata = m0.wdata;
    end else if (gnt1_s) begin
      mem_addr  = m1.addr;
      mem_we    = m1.we && ok1_s;
      mem_wdata = m1.wdata;
    end else begin
      mem_addr  = 32'd0;
      mem_we    = 1'b0;
      mem_wdata = '0;
    end
  end

  // Registered completion: read data or write-ack, with range error
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      err0_r    <= 1'b0;
      err1_r    <= 1'b0;
      rdata0_r  <= '0;
      rdata1_r  <= '0;
    end else begin
      rvalid0_r <= gnt0_s;
      rvalid1_r <= gnt1_s;
      err0_r    <= gnt0_s && !ok0_s;
      err1_r    <= gnt1_s && !ok1_s;
      rdata0_r  <= (gnt0_s && !m0.we && ok0_s) ? mem_rdata : '0;
      rdata1_r  <= (gnt1_s && !m1.we && ok1_s) ? mem_rdata : '0;
    end
  end

  assign m0.gnt    = gnt0_s;
  assign m1.gnt    = gnt1_s;
  assign m0.rvalid = rvalid0_r;
  assign m1.rvalid = rvalid1_r;
  assign m0.err    = err0_r;
  assign m1.err    = err1_r;
  assign m0.rdata  = rdata0_r;
  assign m1.rdata  = rdata1_r;

  dmem_arbiter_chk u_chk (
    .clk    (clk),
    .rst    (rst),
    .gnt0   (gnt0_s),
    .gnt1   (gnt1_s),
    .locked (state_r == LOCKED),
    .mem_we (mem_we)
  );

endmodule

// Structural invariants of the arbiter.
module dmem_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic gnt0,
  input logic gnt1,
  input logic locked,
  input logic mem_we
);

  a_one_hot_gnt: assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));
  a_locked_m0:   assert property (@(posedge clk) disable iff (rst) locked |-> !gnt0);
  a_we_granted:  assert property (@(posedge clk) disable iff (rst) mem_we |-> (gnt0 || gnt1));
  a_rst_no_gnt:  assert property (@(posedge clk) rst |-> !(gnt0 || gnt1));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter: stimulus pushes expected
// responses, a negedge monitor pops and compares them against rvalid.
module tb_dmem_arbiter;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m1_lock = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        pl_we = 1'b0;
  logic [7:0]  pl_addr = 8'd0;
  logic [31:0] pl_data = 32'd0;
  logic [31:0] mem [0:255];

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  resp_t q0[$];
  resp_t q1[$];

  dmem_arbiter_if #(.DW(32)) m0_bus ();
  dmem_arbiter_if #(.DW(32)) m1_bus ();

  dmem_arbiter #(.AW(8), .DW(32), .LOCK_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .m1_lock   (m1_lock),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory with a preload port used only while the DUT is in reset
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    else if (pl_we) mem[pl_addr] <= pl_data;
  end
  assign mem_rdata = mem[mem_addr[7:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Response monitor: every rvalid must match the oldest expected entry due now
  always @(negedge clk) begin
    while (q0.size() > 0 && q0[0].cyc < cyc) begin
      chk("m0_missing_rvalid", 32'd0, 32'd1);
      void'(q0.pop_front());
    end
    while (q1.size() > 0 && q1[0].cyc < cyc) begin
      chk("m1_missing_rvalid", 32'd0, 32'd1);
      void'(q1.pop_front());
    end
    if (m0_bus.rvalid === 1'b1) begin
      if (q0.size() > 0 && q0[0].cyc == cyc) begin
        chk("m0_rdata", m0_bus.rdata, q0[0].data);
        chk("m0_err", {31'd0, m0_bus.err}, {31'd0, q0[0].err});
        void'(q0.pop_front());
      end else begin
        chk("m0_unexpected_rvalid", 32'd1, 32'd0);
      end
    end
    if (m1_bus.rvalid === 1'b1) begin
      if (q1.size() > 0 && q1[0].cyc == cyc) begin
        chk("m1_rdata", m1_bus.rdata, q1[0].data);
        chk("m1_err", {31'd0, m1_bus.err}, {31'd0, q1[0].err});
        void'(q1.pop_front());
      end else begin
        chk("m1_unexpected_rvalid", 32'd1, 32'd0);
      end
    end
  end

  // One cycle of stimulus; checks grants at negedge and queues expected responses
  task automatic step(input logic rs,
                      input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                      input logic lk, input logic eg0, input logic eg1,
                      input logic [31:0] er0, input logic [31:0] er1,
                      input logic ee0, input logic ee1);
    @(posedge clk);
    #1;
    rst = rs;
    m0_bus.req = r0; m0_bus.we = w0; m0_bus.addr = a0; m0_bus.wdata = d0;
    m1_bus.req = r1; m1_bus.we = w1; m1_bus.addr = a1; m1_bus.wdata = d1;
    m1_lock = lk;
    @(negedge clk);
    chk("m0_gnt", {31'd0, m0_bus.gnt}, {31'd0, eg0});
    chk("m1_gnt", {31'd0, m1_bus.gnt}, {31'd0, eg1});
    if (eg0) q0.push_back('{cyc: cyc + 1, data: er0, err: ee0});
    if (eg1) q1.push_back('{cyc: cyc + 1, data: er1, err: ee1});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0,
         1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  pl_a [4];
    logic [31:0] pl_d [4];
    logic [3:0]  cf_pat;
    logic [9:0]  fr_pat;
    pl_a = '{8'd4, 8'd8, 8'd0, 8'd12};
    pl_d = '{32'h14, 32'h5, 32'h1234, 32'hAB};
    cf_pat = 4'b0101;
    fr_pat = 10'b10_0001_0000;

    m0_bus.req = 1'b0; m0_bus.we = 1'b0; m0_bus.addr = 32'd0; m0_bus.wdata = 32'd0;
    m1_bus.req = 1'b0; m1_bus.we = 1'b0; m1_bus.addr = 32'd0; m1_bus.wdata = 32'd0;

    // Preload memory while held in reset
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pl_we = 1'b1; pl_addr = pl_a[i]; pl_data = pl_d[i];
    end
    @(posedge clk); #1;
    pl_we = 1'b0;

    // Requests during reset are never granted; outputs at reset values
    step(1'b1, 1'b1, 1'b1, 32'd4, 32'd9, 1'b1, 1'b1, 32'd8, 32'd9, 1'b1,
         1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_m0_rvalid", {31'd0, m0_bus.rvalid}, 32'd0);
    chk("rst_m0_rdata", m0_bus.rdata, 32'd0);
    chk("rst_m1_err", {31'd0, m1_bus.err}, 32'd0);

    // Conflict after reset: m0 first, then alternate
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b0, 32'd12, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b0,
           cf_pat[i], !cf_pat[i], 32'hAB, 32'h14, 1'b0, 1'b0);
    idle();

    // Single read
    step(1'b0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0,
         1'b1, 1'b0, 32'h14, 32'd0, 1'b0, 1'b0);
    idle();

    // Locked read-modify-write with m0 held pending
    step(1'b0, 1'b1, 1'b0, 32'd12, 32'd0, 1'b1, 1'b0, 32'd8, 32'd0, 1'b1,
         1'b0, 1'b1, 32'd0, 32'h5, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd12, 32'd0, 1'b1, 1'b1, 32'd8, 32'h6, 1'b1,
         1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("rmw_mem_we", {31'd0, mem_we}, 32'd1);
    chk("rmw_mem_addr", mem_addr, 32'd8);
    chk("rmw_mem_wdata", mem_wdata, 32'h6);
    step(1'b0, 1'b1, 1'b0, 32'd12, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0,
         1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd12, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0,
         1'b1, 1'b0, 32'hAB, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd8, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0,
         1'b1, 1'b0, 32'h6, 32'd0, 1'b0, 1'b0);
    idle();

    // Forced release after LOCK_MAX consecutive m1 grants
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 1'b0, 32'd12, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b1,
           fr_pat[i], !fr_pat[i], 32'hAB, 32'h14, 1'b0, 1'b0);
    idle();

    // Out-of-range write is suppressed and flagged; memory word 0 unaffected
    step(1'b0, 1'b1, 1'b1, 32'h100, 32'hDEAD, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0,
         1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("oob_mem_we", {31'd0, mem_we}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0,
         1'b1, 1'b0, 32'h1234, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h8000_0004, 32'd0, 1'b0,
         1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1);

    // Read-after-write in the next cycle
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd12, 32'h77, 1'b0,
         1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd12, 32'd0, 1'b0,
         1'b0, 1'b1, 32'd0, 32'h77, 1'b0, 1'b0);

    // Reset in the middle of a lock, then m0 wins the first conflict
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b1,
         1'b0, 1'b1, 32'd0, 32'h14, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'd8, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b1,
         1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd8, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b0,
         1'b1, 1'b0, 32'h6, 32'd0, 1'b0, 1'b0);
    chk("post_rst_m1_rvalid", {31'd0, m1_bus.rvalid}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd8, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b0,
         1'b0, 1'b1, 32'd0, 32'h14, 1'b0, 1'b0);
    idle();
    idle();
    idle();

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer placed in front of the single-port word-addressed data memory. Requester 0 is the pipeline MEM stage; requester 1 is the CSR/trap unit, which saves and restores context words. The block grants one access per cycle using round-robin priority. It supports a locked sequence so requester 1 can do an uninterrupted read-modify-write, registers read data back to the winner, and flags out-of-range accesses.

## Interface
Parameters:
- AW, 8, word-address bits; valid addresses are 0 .. 2**AW-1
- DW, 32, data width
- LOCK_MAX, 4, maximum consecutive cycles requester 1 may hold the lock

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- m0_req  in  1  pipeline access request
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  32  word address
- m0_wdata  in  DW  write data
- m0_gnt  out  1  access accepted this cycle; low = pipeline must stall MEM
- m0_rvalid  out  1  read response valid (one cycle after a granted read)
- m0_rdata  out  DW  read data, registered
- m0_err  out  1  accompanies m0_rvalid or write-ack; address out of range
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err  same as m0_* for the CSR unit
- m1_lock  in  1  hold grant for requester 1 while asserted
- mem_addr  out  32  to memory address input
- mem_we  out  1  to memory write enable
- mem_wdata  out  DW  to memory write data
- mem_rdata  in  DW  combinational read data from memory

## Operation
- States: IDLE, LOCKED.
- Priority register `last` holds the last winner. Reset value is 1, so m0 wins the first conflict.
- In IDLE:
  - If one requester asserts req, that requester is granted.
  - If both assert req, the requester not equal to `last` is granted.
  - `last` updates on every grant.
- Entering LOCKED: from IDLE, when m1 is granted with m1_lock=1, the next state is LOCKED and the lock counter is set to 1.
- In LOCKED:
  - Only m1 can be granted; m0_gnt=0 regardless of m0_req.
  - The counter increments on each LOCKED cycle.
  - Exit to IDLE when m1_lock=0, or when the counter reaches LOCK_MAX (forced release).
  - On a forced release, `last`=1, so a pending m0 wins next.
- Grant is combinational from req, state and `last`. mem_addr, mem_we and mem_wdata are muxed from the granted requester.
- When nothing is granted: mem_we=0, mem_addr=0, mem_wdata=0.
- Range check: address >= 2**AW is out of range.
  - mem_we is forced to 0 for that access.
  - The registered rdata is 0.
  - The err bit pulses together with the response.
- Writes also produce a one-cycle rvalid (write-ack) with rdata=0, so both requesters see a uniform completion.
- An ungranted requester must hold req, we, addr and wdata stable until granted.

## Timing
- Grant: same cycle as req (zero-latency arbitration).
- A write commits at the posedge that ends the grant cycle.
- Read: mem_rdata is sampled at the posedge that ends the grant cycle. xN_rvalid and xN_rdata are valid the whole following cycle.
- Throughput: one access per cycle total. Back-to-back grants to the same requester are allowed only when the other requester is idle or the arbiter is LOCKED.
- Read-after-write to the same address in the next cycle returns the new data.
- Reset values: state=IDLE, `last`=1, lock counter=0, all gnt/rvalid/err=0, rdata=0, mem_we=0.
- Reset mid-LOCKED aborts the lock. No response is issued for the access granted in the reset cycle.
- While rst=1 all grants are 0.
- Simultaneous m1_lock deassert and new m0_req: the lock releases in that cycle and m0 is granted the following cycle.

## Test plan
- Single read: preload addr 4 = 0x14; m0 reads addr 4 → m0_gnt same cycle; next cycle m0_rvalid=1, m0_rdata=0x14, m0_err=0.
- Conflict round-robin: both requesters hold req for 4 cycles after reset → grants alternate m0, m1, m0, m1; `last` toggles each cycle.
- Locked RMW: m1 reads addr 8 with lock (data 0x5), then writes 0x6 with lock, then releases while m0_req is held throughout → m0_gnt=0 during the lock; m0 granted the cycle after release; a later read of addr 8 returns 0x6.
- Forced release: m1 holds m1_lock and req for 10 cycles with LOCK_MAX=4, m0 requesting → m1 granted exactly 4 consecutive cycles, then m0 granted.
- Out of range: m0 writes 0xDEAD to addr 0x100 (AW=8) → mem_we=0; next cycle m0_rvalid=1, m0_err=1; memory contents unchanged.
- Reset mid-lock: assert rst during LOCKED with m1 granted → next cycle state=IDLE, all gnt/rvalid=0; after rst drops, simultaneous requests grant m0 first.
